gate_stim_checker: RTL and testbench

- Self-checking stimulus and response stage wrapped around the two-input logic-gate block.
- Drives the gate block's `a`/`b` inputs through all four input combinations and waits a programmable settle time per vector.
- Samples the seven gate outputs, compares them against golden values and reports an error count with a pass/done status.
- Replaces the free-running, unchecked stimulus with a synthesizable, restartable checker usable in simulation or on-chip BIST.

---
 rtl/gate_stim_checker.sv | 147 ++++++++++++++
 tb/tb_gate_stim_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gate_stim_checker.sv
// rtl/gate_stim_checker.sv - restartable stimulus/compare checker for the two-input gate block.
// Optional first-failure capture is built when GATE_CHK_FIRST_FAIL_EN is defined.
module gate_stim_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] fail_idx,
    output logic [6:0] fail_obs
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);
    localparam state_t     VEC_ENTRY = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] pass_cnt_q, pass_cnt_d;
    logic [7:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       mismatch;
    logic       accept;

    function automatic logic [6:0] golden(input logic [1:0] i);
        case (i)
            2'd0:    golden = 7'h5C;
            2'd1:    golden = 7'h2E;
            2'd2:    golden = 7'h2A;
            default: golden = 7'h43;
        endcase
    endfunction

    assign mismatch = (gate_out != golden(idx_q));
    assign accept   = (state_q == S_IDLE) && start;

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        idx_d      = idx_q;
        pass_cnt_d = pass_cnt_q;
        err_d      = err_q;
        pass_d     = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d      = 2'd0;
                    pass_cnt_d = 8'd0;
                    err_d      = 8'd0;
                    pass_d     = 1'b0;
                    settle_d   = SETTLE_LD;
                    state_d    = VEC_ENTRY;
                end
            end
            // The settle counter runs SETTLE_CYCLES cycles; CHECK is the vector's final held cycle.
            S_SETTLE: begin
                settle_d = settle_q - 4'd1;
                if (settle_q <= 4'd1) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mismatch && (err_q != 8'hFF)) begin
                    err_d = err_q + 8'd1;
                end
                if ((idx_q == 2'd3) && (pass_cnt_q == LAST_PASS)) begin
                    pass_d  = (err_d == 8'd0);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        pass_cnt_d = pass_cnt_q + 8'd1;
                    end
                    settle_d = SETTLE_LD;
                    state_d  = VEC_ENTRY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            settle_q   <= 4'd0;
            idx_q      <= 2'd0;
            pass_cnt_q <= 8'd0;
            err_q      <= 8'd0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            idx_q      <= idx_d;
            pass_cnt_q <= pass_cnt_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [1:0] fail_idx_q;
    logic [6:0] fail_obs_q;

    // A zero error count before this CHECK marks the first mismatch of the run.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            fail_idx_q <= 2'd0;
            fail_obs_q <= 7'd0;
        end else if ((state_q == S_CHECK) && mismatch && (err_q == 8'd0)) begin
            fail_idx_q <= idx_q;
            fail_obs_q <= gate_out;
        end
    end

    assign fail_idx = fail_idx_q;
    assign fail_obs = fail_obs_q;
`else
    assign fail_idx = 2'd0;
    assign fail_obs = 7'd0;
`endif

    assign a         = idx_q[1];
    assign b         = idx_q[0];
    assign busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// tb/tb_gate_stim_checker.sv - directed and randomized self-checking bench for gate_stim_checker.
module tb_gate_stim_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start;
    logic [6:0] sa0 [4];
    logic [6:0] sa1 [4];
    logic [6:0] gout [4];

    wire  [3:0] a_w;
    wire  [3:0] b_w;
    wire  [3:0] busy_w;
    wire  [3:0] done_w;
    wire  [3:0] pass_w;
    wire  [7:0] err_w  [4];
    wire  [1:0] fidx_w [4];
    wire  [6:0] fobs_w [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] ideal(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    // Gate block model with per-bit stuck-at faults.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            gout[k] = (ideal(a_w[k], b_w[k]) & ~sa0[k]) | sa1[k];
        end
    end

    gate_stim_checker #(.SETTLE_CYCLES(2), .PASSES(1)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .a(a_w[0]), .b(b_w[0]), .gate_out(gout[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
        .fail_idx(fidx_w[0]), .fail_obs(fobs_w[0]));

    gate_stim_checker #(.SETTLE_CYCLES(0), .PASSES(3)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .a(a_w[1]), .b(b_w[1]), .gate_out(gout[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
        .fail_idx(fidx_w[1]), .fail_obs(fobs_w[1]));

    gate_stim_checker #(.SETTLE_CYCLES(1), .PASSES(2)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .a(a_w[2]), .b(b_w[2]), .gate_out(gout[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]),
        .fail_idx(fidx_w[2]), .fail_obs(fobs_w[2]));

    gate_stim_checker #(.SETTLE_CYCLES(0), .PASSES(255)) u_d (
        .clk(clk), .rst(rst), .start(start[3]), .a(a_w[3]), .b(b_w[3]), .gate_out(gout[3]),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_count(err_w[3]),
        .fail_idx(fidx_w[3]), .fail_obs(fobs_w[3]));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int k);
        chk($sformatf("rst_a[%0d]", k), int'(a_w[k]), 0);
        chk($sformatf("rst_b[%0d]", k), int'(b_w[k]), 0);
        chk($sformatf("rst_busy[%0d]", k), int'(busy_w[k]), 0);
        chk($sformatf("rst_done[%0d]", k), int'(done_w[k]), 0);
        chk($sformatf("rst_pass[%0d]", k), int'(pass_w[k]), 0);
        chk($sformatf("rst_err[%0d]", k), int'(err_w[k]), 0);
        chk($sformatf("rst_fidx[%0d]", k), int'(fidx_w[k]), 0);
        chk($sformatf("rst_fobs[%0d]", k), int'(fobs_w[k]), 0);
    endtask

    // One complete run on instance k; expectations come from sweeping the fault masks
    // over the four vectors and scaling by the pass count.
    task automatic do_run(input int k, input int s, input int p,
                          input logic [6:0] m0, input logic [6:0] m1, input bit glitch);
        int         per_pass;
        int         first;
        int         exp_err;
        int         exp_fidx;
        int         exp_fobs;
        int         n;
        int         budget;
        logic [1:0] iv;
        logic [6:0] good;
        logic [6:0] seen;
        sa0[k]   = m0;
        sa1[k]   = m1;
        per_pass = 0;
        first    = -1;
        exp_fobs = 0;
        for (int i = 0; i < 4; i++) begin
            iv   = 2'(i);
            good = ideal(iv[1], iv[0]);
            seen = (good & ~m0) | m1;
            if (seen != good) begin
                per_pass++;
                if (first < 0) begin
                    first    = i;
                    exp_fobs = int'(seen);
                end
            end
        end
        exp_err = (per_pass * p > 255) ? 255 : per_pass * p;
`ifdef GATE_CHK_FIRST_FAIL_EN
        exp_fidx = (first < 0) ? 0 : first;
`else
        exp_fidx = 0;
        exp_fobs = 0;
`endif
        budget = p * 4 * (s + 1) + 10;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        chk($sformatf("busy_rise[%0d]", k), int'(busy_w[k]), 1);
        chk($sformatf("pass_clr[%0d]", k), int'(pass_w[k]), 0);
        n = 0;
        while (busy_w[k] && n < budget) begin
            chk($sformatf("vec[%0d]@%0d", k, n), int'({a_w[k], b_w[k]}), (n / (s + 1)) % 4);
            if (glitch) start[k] = 1'($urandom_range(0, 1));
            n++;
            @(negedge clk);
        end
        chk($sformatf("busy_len[%0d]", k), n, p * 4 * (s + 1));
        chk($sformatf("done[%0d]", k), int'(done_w[k]), 1);
        chk($sformatf("pass[%0d]", k), int'(pass_w[k]), (exp_err == 0) ? 1 : 0);
        chk($sformatf("err[%0d]", k), int'(err_w[k]), exp_err);
        chk($sformatf("fidx[%0d]", k), int'(fidx_w[k]), exp_fidx);
        chk($sformatf("fobs[%0d]", k), int'(fobs_w[k]), exp_fobs);
        if (glitch) begin
            start[k] = 1'b1;
            @(negedge clk);
            start[k] = 1'b0;
            chk($sformatf("start_in_done[%0d]", k), int'(busy_w[k]), 0);
        end else begin
            start[k] = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("done_fall[%0d]", k), int'(done_w[k]), 0);
        chk($sformatf("pass_hold[%0d]", k), int'(pass_w[k]), (exp_err == 0) ? 1 : 0);
    endtask

    initial begin
        logic [6:0] r0;
        logic [6:0] r1;
        rst   = 1'b1;
        start = 4'd0;
        for (int k = 0; k < 4; k++) begin
            sa0[k] = 7'd0;
            sa1[k] = 7'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) chk_reset(k);
        rst = 1'b0;
        @(negedge clk);

        do_run(0, 2, 1, 7'h00, 7'h00, 1'b0);
        do_run(2, 1, 2, 7'h20, 7'h00, 1'b0);
        do_run(2, 1, 2, 7'h00, 7'h00, 1'b0);

        for (int t = 0; t < 6; t++) begin
            r0 = 7'($urandom) & 7'h7F;
            r1 = 7'($urandom) & ~r0;
            if (t % 3 == 0) r1 = 7'h00;
            do_run(2, 1, 2, r0, r1, 1'b0);
        end

        // Mid-run reset while vector 2 of pass 0 is on the outputs.
        sa0[0]   = 7'h10;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrun_vec2", int'({a_w[0], b_w[0]}), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset(0);
        do_run(0, 2, 1, 7'h00, 7'h00, 1'b0);

        do_run(1, 0, 3, 7'h00, 7'h00, 1'b1);
        do_run(1, 0, 3, 7'h00, 7'h01, 1'b1);
        do_run(1, 0, 3, 7'h00, 7'h00, 1'b0);

        do_run(3, 0, 255, 7'h7F, 7'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
